// File: rtl/nmea_mwv_tx.sv
// nmea_mwv_tx
// Emits one NMEA 0183 MWV wind sentence per accepted start request over a
// UART 8N1 line:
//   "$WIMWV,000,R,ddd,K,A*hh" CR LF   (NMEA_MWV_TX_CHECKSUM_EN defined)
//   "$WIMWV,000,R,ddd,K,A" CR LF      (NMEA_MWV_TX_CHECKSUM_EN undefined)
// ddd is the latched speed as three zero-padded decimal digits. hh is the XOR
// of every character between '$' and '*', written as uppercase hex.
//
// Parameters:
//   CLK_FREQ  clock frequency in Hz
//   BAUD      serial bit rate; one bit lasts DIV = CLK_FREQ/BAUD cycles
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; aborts any sentence in progress
//   speed  wind speed in km/h, latched when a start is accepted
//   start  one-cycle request; accepted only while busy is low
//   busy   high from the cycle after an accepted start up to the done cycle
//   done   one-cycle pulse once the last stop bit has finished
//   tx     registered serial output, idle high
//
// Handshake: start is a request, busy is the inverted ready. A start sampled
// while busy=0 (and reset=0) is accepted on that edge; any other start is
// dropped without effect. done and the busy falling edge share one cycle, so
// a start presented in the done cycle is accepted.
//
// tx and done are registered from the FSM state, so both lag the state by
// one cycle: the start bit leaves the line 9 cycles after the accept edge
// (8 conversion cycles plus the output register), and done appears in the
// cycle right after the final stop bit time.
module nmea_mwv_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 4800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] speed,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] DIV_M1 = BW'(DIV - 1);
`ifdef NMEA_MWV_TX_CHECKSUM_EN
  localparam logic [4:0] LAST_CHAR = 5'd24;
`else
  localparam logic [4:0] LAST_CHAR = 5'd21;
`endif

  typedef enum logic [2:0] {IDLE, CONV, SEND_START, SEND_DATA, SEND_STOP} state_t;

  state_t          state_q;
  logic [7:0]      bin_q;       // speed being shifted into the BCD register
  logic [11:0]     bcd_q;       // hundreds, tens, units
  logic [2:0]      conv_cnt_q;
  logic [BW-1:0]   baud_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [4:0]      char_idx_q;
  logic            fin_q;       // last stop bit done, done pulse due next
  logic            tx_q;
  logic            busy_q;
  logic            done_q;
`ifdef NMEA_MWV_TX_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  logic [11:0]     bcd_adj;
  logic [7:0]      char_cur;
  logic            bit_end;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Character for the current index. Stable for the whole character because
  // the checksum only updates at the end of a stop bit.
  always_comb begin
    char_cur = 8'h20;
    case (char_idx_q)
      5'd0:  char_cur = 8'h24;                       // '$'
      5'd1:  char_cur = 8'h57;                       // 'W'
      5'd2:  char_cur = 8'h49;                       // 'I'
      5'd3:  char_cur = 8'h4D;                       // 'M'
      5'd4:  char_cur = 8'h57;                       // 'W'
      5'd5:  char_cur = 8'h56;                       // 'V'
      5'd6:  char_cur = 8'h2C;
      5'd7:  char_cur = 8'h30;
      5'd8:  char_cur = 8'h30;
      5'd9:  char_cur = 8'h30;
      5'd10: char_cur = 8'h2C;
      5'd11: char_cur = 8'h52;                       // 'R'
      5'd12: char_cur = 8'h2C;
      5'd13: char_cur = {4'h3, bcd_q[11:8]};
      5'd14: char_cur = {4'h3, bcd_q[7:4]};
      5'd15: char_cur = {4'h3, bcd_q[3:0]};
      5'd16: char_cur = 8'h2C;
      5'd17: char_cur = 8'h4B;                       // 'K'
      5'd18: char_cur = 8'h2C;
      5'd19: char_cur = 8'h41;                       // 'A'
`ifdef NMEA_MWV_TX_CHECKSUM_EN
      5'd20: char_cur = 8'h2A;                       // '*'
      5'd21: char_cur = hex_ascii(csum_q[7:4]);
      5'd22: char_cur = hex_ascii(csum_q[3:0]);
      5'd23: char_cur = 8'h0D;
      5'd24: char_cur = 8'h0A;
`else
      5'd20: char_cur = 8'h0D;
      5'd21: char_cur = 8'h0A;
`endif
      default: char_cur = 8'h20;
    endcase
  end

  assign bit_end = (baud_cnt_q == DIV_M1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_q      <= 8'h00;
      bcd_q      <= 12'h000;
      conv_cnt_q <= 3'd0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      char_idx_q <= 5'd0;
      fin_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef NMEA_MWV_TX_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      done_q <= 1'b0;

      // Line level follows the state of the previous cycle.
      case (state_q)
        SEND_START: tx_q <= 1'b0;
        SEND_DATA:  tx_q <= char_cur[bit_cnt_q];
        default:    tx_q <= 1'b1;
      endcase

      case (state_q)
        IDLE: begin
          if (fin_q) begin
            fin_q  <= 1'b0;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else if (start) begin
            bin_q      <= speed;
            bcd_q      <= 12'h000;
            conv_cnt_q <= 3'd0;
            busy_q     <= 1'b1;
            state_q    <= CONV;
          end
        end
        CONV: begin
          {bcd_q, bin_q} <= {bcd_adj[10:0], bin_q, 1'b0};
          conv_cnt_q     <= conv_cnt_q + 3'd1;
          if (conv_cnt_q == 3'd7) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            char_idx_q <= 5'd0;
`ifdef NMEA_MWV_TX_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
            state_q    <= SEND_START;
          end
        end
        SEND_START: begin
          baud_cnt_q <= bit_end ? '0 : baud_cnt_q + BW'(1);
          if (bit_end) begin
            bit_cnt_q <= 3'd0;
            state_q   <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          baud_cnt_q <= bit_end ? '0 : baud_cnt_q + BW'(1);
          if (bit_end) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= SEND_STOP;
          end
        end
        SEND_STOP: begin
          baud_cnt_q <= bit_end ? '0 : baud_cnt_q + BW'(1);
          if (bit_end) begin
`ifdef NMEA_MWV_TX_CHECKSUM_EN
            // Characters 1..19 are the ones between '$' and '*'.
            if (char_idx_q >= 5'd1 && char_idx_q <= 5'd19) csum_q <= csum_q ^ char_cur;
`endif
            if (char_idx_q == LAST_CHAR) begin
              fin_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              char_idx_q <= char_idx_q + 5'd1;
              state_q    <= SEND_START;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_nmea_mwv_tx.sv
module tb_nmea_mwv_tx;

  localparam int DIV = 8;
`ifdef NMEA_MWV_TX_CHECKSUM_EN
  localparam int SENT_CYC = 250 * DIV;
`else
  localparam int SENT_CYC = 220 * DIV;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] speed;
  logic       start;
  logic       busy;
  logic       done;
  logic       tx;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int frame_errs = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] mon_b;

  nmea_mwv_tx #(.CLK_FREQ(8), .BAUD(1)) dut (
    .clk   (clk),
    .reset (reset),
    .speed (speed),
    .start (start),
    .busy  (busy),
    .done  (done),
    .tx    (tx)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // ---------------- UART monitor (samples mid-bit on negedges) ----------------
  always begin
    @(negedge clk);
    if (reset === 1'b0 && tx === 1'b0) begin
      repeat (3) @(negedge clk);
      mon_b = 8'h00;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        mon_b[i] = tx;
      end
      repeat (DIV) @(negedge clk);
      if (tx !== 1'b1) frame_errs++;
      rx_q.push_back(mon_b);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string sentence(input string digits, input string cks);
`ifdef NMEA_MWV_TX_CHECKSUM_EN
    return {"$WIMWV,000,R,", digits, ",K,A*", cks};
`else
    return {"$WIMWV,000,R,", digits, ",K,A"};
`endif
  endfunction

  task automatic check_rx(input string tag, input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    check({tag, " length"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s char %0d", tag, i), rx_q[i], exp_q[i]);
    check({tag, " framing"}, frame_errs, 0);
    rx_q.delete();
    frame_errs = 0;
  endtask

  // Drive a start from the current negedge; returns the accept edge number.
  // Ends at the negedge where the first start bit is visible.
  task automatic start_sentence(input logic [7:0] spd, input string tag, output int acc);
    int n;
    speed = spd;
    start = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    speed = ~spd;
    check({tag, " busy after accept"}, busy, 1'b1);
    n = 0;
    while (tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " first start bit"}, cyc - acc, 9);
  endtask

  // Ends at the negedge where done is high (or when the budget runs out).
  task automatic wait_done(input int acc, input string tag);
    int n;
    int busy_low;
    n = 0;
    busy_low = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
      if (done !== 1'b1 && busy !== 1'b1) busy_low++;
    end
    check({tag, " done seen"}, done, 1'b1);
    check({tag, " done latency"}, cyc - acc, 9 + SENT_CYC);
    check({tag, " busy held"}, busy_low, 0);
    check({tag, " busy clear at done"}, busy, 1'b0);
  endtask

  task automatic wait_rx(input int n_chars, input string tag);
    int n;
    n = 0;
    while (rx_q.size() < n_chars && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " chars received"}, rx_q.size() >= n_chars, 1'b1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int acc;
    int d0;
    int lows;

    // Reset with a coincident start: the start must be dropped.
    reset = 1'b1;
    start = 1'b1;
    speed = 8'd5;
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("start with reset ignored", busy, 1'b0);
    check("idle tx", tx, 1'b1);
    repeat (4) @(negedge clk);

    // Basic sentences.
    d0 = done_cnt;
    start_sentence(8'd0, "s000", acc);
    wait_done(acc, "s000");
    check_rx("s000", sentence("000", "26"));
    @(negedge clk);
    check("s000 done single pulse", done_cnt - d0, 1);
    repeat (3) @(negedge clk);

    start_sentence(8'd255, "s255", acc);
    wait_done(acc, "s255");
    check_rx("s255", sentence("255", "24"));
    repeat (3) @(negedge clk);

    start_sentence(8'd7, "s007", acc);
    wait_done(acc, "s007");
    check_rx("s007", sentence("007", "21"));
    repeat (3) @(negedge clk);

    start_sentence(8'd123, "s123", acc);
    wait_done(acc, "s123");
    check_rx("s123", sentence("123", "26"));
    repeat (3) @(negedge clk);

    // A start while busy must not disturb the sentence in progress.
    d0 = done_cnt;
    start_sentence(8'd0, "busy_start", acc);
    wait_rx(5, "busy_start");
    speed = 8'd99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(acc, "busy_start");
    check_rx("busy_start", sentence("000", "26"));
    repeat (40) @(negedge clk);
    check("busy_start one done", done_cnt - d0, 1);
    check("busy_start stays idle", busy, 1'b0);

    // Reset in the middle of a sentence aborts it for good.
    d0 = done_cnt;
    start_sentence(8'd0, "abort", acc);
    wait_rx(10, "abort");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort tx", tx, 1'b1);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("abort line stays high", lows, 0);
    check("abort no done", done_cnt - d0, 0);
    check("abort no resume", busy, 1'b0);
    rx_q.delete();
    frame_errs = 0;
    start_sentence(8'd0, "after_abort", acc);
    wait_done(acc, "after_abort");
    check_rx("after_abort", sentence("000", "26"));
    repeat (3) @(negedge clk);

    // Back-to-back: start presented in the done cycle.
    start_sentence(8'd0, "b2b_first", acc);
    wait_done(acc, "b2b_first");
    check_rx("b2b_first", sentence("000", "26"));
    start_sentence(8'd255, "b2b_second", acc);
    wait_done(acc, "b2b_second");
    check_rx("b2b_second", sentence("255", "24"));
    repeat (5) @(negedge clk);
    check("final idle tx", tx, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
